// File: rtl/maze_walker_if.sv
// Request/response and row-ROM signals of the maze walker, bundled as one port.
// Latency: none, wires only.
// Backpressure: move_ready qualifies move_valid; requests seen while it is low are dropped.
interface maze_walker_if;
  logic       move_valid;
  logic [1:0] move_dir;
  logic       move_ready;
  logic       rom_en;
  logic [2:0] rom_addr;
  logic [7:0] rom_data;
  logic [2:0] pos_x;
  logic [2:0] pos_y;
  logic       move_done;
  logic       move_ok;
  logic       at_goal;

  // Walker side: consumes requests and ROM data, drives everything else.
  modport slave (
    input  move_valid, move_dir, rom_data,
    output move_ready, rom_en, rom_addr, pos_x, pos_y, move_done, move_ok, at_goal
  );

  // Requester/ROM side, as seen from the environment of the walker.
  modport master (
    output move_valid, move_dir, rom_data,
    input  move_ready, rom_en, rom_addr, pos_x, pos_y, move_done, move_ok, at_goal
  );
endinterface

// File: rtl/maze_walker.sv
// Walks a 8x8 grid one step per request, checking walls in a registered row ROM.
// Latency: move_done 3 cycles after accept for in-grid targets, 1 cycle for off-grid ones.
// Backpressure: move_ready only in IDLE and away from the goal; otherwise requests are ignored.
module maze_walker #(
  parameter logic [2:0] START_X = 3'd2,
  parameter logic [2:0] START_Y = 3'd0,
  parameter logic [2:0] GOAL_X  = 3'd0,
  parameter logic [2:0] GOAL_Y  = 3'd7
) (
  input logic          clk,
  input logic          rst,
  maze_walker_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t     state;
  state_t     state_nxt;

  logic [2:0] pos_x;
  logic [2:0] pos_y;
  logic [2:0] tx;
  logic [2:0] ty;
  logic [2:0] tx_nxt;
  logic [2:0] ty_nxt;
  logic       out_of_grid;
  logic       ok;
  logic       at_goal;
  logic       ready;
  logic       accept;
  logic       cell_open;

  // Goal is a pure decode of the registered position, so it can never glitch ahead of pos.
  assign at_goal = (pos_x == GOAL_X) && (pos_y == GOAL_Y);
  assign ready   = (state == IDLE) && !at_goal;
  assign accept  = ready && bus.move_valid;

  // Column x lives at bit (7-x) of the row word.
  assign cell_open = bus.rom_data[3'd7 - tx];

  // Target cell from the requested direction; edges are flagged instead of wrapping.
  always_comb begin
    tx_nxt      = pos_x;
    ty_nxt      = pos_y;
    out_of_grid = 1'b0;
    case (bus.move_dir)
      2'd0: begin
        if (pos_y == 3'd0) out_of_grid = 1'b1;
        else               ty_nxt      = pos_y - 3'd1;
      end
      2'd1: begin
        if (pos_x == 3'd7) out_of_grid = 1'b1;
        else               tx_nxt      = pos_x + 3'd1;
      end
      2'd2: begin
        if (pos_y == 3'd7) out_of_grid = 1'b1;
        else               ty_nxt      = pos_y + 3'd1;
      end
      default: begin
        if (pos_x == 3'd0) out_of_grid = 1'b1;
        else               tx_nxt      = pos_x - 3'd1;
      end
    endcase
  end

  // State register; reset drops any in-flight move without a done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state: off-grid moves skip the ROM round trip and finish straight away.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) state_nxt = out_of_grid ? DONE : FETCH;
      end
      FETCH:   state_nxt = CHECK;
      CHECK:   state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  // Target is captured at accept so the ROM address and wall test use a stable cell.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx <= START_X;
      ty <= START_Y;
    end else if (accept) begin
      tx <= tx_nxt;
      ty <= ty_nxt;
    end
  end

  // Position and verdict: off-grid verdict is set at accept, in-grid verdict once ROM data is back.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pos_x <= START_X;
      pos_y <= START_Y;
      ok    <= 1'b0;
    end else if (accept && out_of_grid) begin
      ok <= 1'b0;
    end else if (state == CHECK) begin
      ok <= cell_open;
      if (cell_open) begin
        pos_x <= tx;
        pos_y <= ty;
      end
    end
  end

  // Outputs are decoded from registered state only; the ROM is touched in FETCH alone.
  always_comb begin
    bus.rom_en    = 1'b0;
    bus.rom_addr  = 3'd0;
    if (state == FETCH) begin
      bus.rom_en   = 1'b1;
      bus.rom_addr = ty;
    end
  end

  assign bus.move_ready = ready;
  assign bus.move_done  = (state == DONE);
  assign bus.move_ok    = ok;
  assign bus.pos_x      = pos_x;
  assign bus.pos_y      = pos_y;
  assign bus.at_goal    = at_goal;

endmodule

// File: tb/tb_maze_walker.sv
// Self-checking bench for maze_walker against a grid-level reference model.
// Latency: checks done timing per move relative to the accept edge.
// Backpressure: checks that requests are dropped while busy or at the goal.
module tb_maze_walker;

  logic clk;
  logic rst;
  maze_walker_if bus ();

  maze_walker dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int tests = 0;
  int fails = 0;

  logic [7:0] map [8];
  int mx;
  int my;
  bit mok;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered row ROM: data appears the cycle after rom_en.
  always @(posedge clk) begin
    if (bus.rom_en) bus.rom_data <= map[bus.rom_addr];
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Assumes the caller is at a falling edge; returns at a falling edge.
  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_pos_x", bus.pos_x, 2);
    chk("rst_pos_y", bus.pos_y, 0);
    chk("rst_done", bus.move_done, 0);
    chk("rst_ok", bus.move_ok, 0);
    chk("rst_rom_en", bus.rom_en, 0);
    chk("rst_rom_addr", bus.rom_addr, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_ready", bus.move_ready, 1);
    chk("post_rst_goal", bus.at_goal, 0);
    mx = 2;
    my = 0;
    mok = 1'b0;
    @(negedge clk);
  endtask

  // One request, observed for six cycles after the accept edge.
  task automatic do_move(input logic [1:0] d);
    int nx, ny, done_at, done_cnt, en_cnt;
    bit goal, oob, open;
    goal = (mx == 0) && (my == 7);
    nx = mx;
    ny = my;
    case (d)
      2'd0: ny = ny - 1;
      2'd1: nx = nx + 1;
      2'd2: ny = ny + 1;
      default: nx = nx - 1;
    endcase
    oob  = (nx < 0) || (nx > 7) || (ny < 0) || (ny > 7);
    open = 1'b0;
    if (!oob) open = map[ny][7 - nx];

    bus.move_valid = 1'b1;
    bus.move_dir   = d;
    chk("ready_before", bus.move_ready, !goal);
    @(posedge clk);
    @(negedge clk);
    bus.move_valid = 1'b0;
    done_at  = 0;
    done_cnt = 0;
    en_cnt   = 0;
    for (int i = 1; i <= 6; i++) begin
      if (bus.move_done) begin
        done_cnt++;
        if (done_at == 0) begin
          done_at = i;
          chk("done_ok", bus.move_ok, open);
        end
      end
      if (bus.rom_en) begin
        en_cnt++;
        chk("rom_addr", bus.rom_addr, ny);
      end else begin
        chk("rom_addr_idle", bus.rom_addr, 0);
      end
      if (i == 1 && !goal && !oob) chk("ok_hold", bus.move_ok, mok);
      if (i < 6) @(negedge clk);
    end
    chk("done_cycle", done_at, goal ? 0 : (oob ? 1 : 3));
    chk("done_count", done_cnt, goal ? 0 : 1);
    chk("rom_en_count", en_cnt, (goal || oob) ? 0 : 1);
    if (!goal) begin
      if (open) begin
        mx = nx;
        my = ny;
      end
      mok = open;
    end
    chk("pos_x", bus.pos_x, mx);
    chk("pos_y", bus.pos_y, my);
    chk("ok_after", bus.move_ok, mok);
    chk("at_goal", bus.at_goal, (mx == 0) && (my == 7));
  endtask

  initial begin
    int done_cnt, rdy_cnt;
    rst = 1'b1;
    bus.move_valid = 1'b0;
    bus.move_dir   = 2'd0;
    bus.rom_data   = 8'h00;
    for (int r = 0; r < 8; r++) map[r] = 8'hFF;
    @(negedge clk);
    @(negedge clk);

    // Right, wall and edge moves on row 0 = 00111111.
    map[0] = 8'b0011_1111;
    do_reset();
    do_move(2'd3);
    do_move(2'd0);
    do_move(2'd1);

    // Held request: one accept per four-cycle transaction.
    for (int r = 0; r < 8; r++) map[r] = 8'hFF;
    do_reset();
    bus.move_valid = 1'b1;
    bus.move_dir   = 2'd1;
    done_cnt = 0;
    rdy_cnt  = 0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (bus.move_done) done_cnt++;
      if (bus.move_ready) rdy_cnt++;
    end
    bus.move_valid = 1'b0;
    chk("busy_dones", done_cnt, 3);
    chk("busy_ready_cycles", rdy_cnt, 3);
    repeat (6) @(negedge clk);
    chk("busy_pos_x", bus.pos_x, 5);
    mx = 5;
    mok = 1'b1;

    // Reset during FETCH aborts the move.
    do_reset();
    do_move(2'd1);
    bus.move_valid = 1'b1;
    bus.move_dir   = 2'd1;
    @(posedge clk);
    @(negedge clk);
    bus.move_valid = 1'b0;
    chk("abort_in_fetch", bus.rom_en, 1);
    rst = 1'b1;
    #1;
    chk("abort_pos_x", bus.pos_x, 2);
    chk("abort_pos_y", bus.pos_y, 0);
    chk("abort_rom_en", bus.rom_en, 0);
    chk("abort_done", bus.move_done, 0);
    @(negedge clk);
    rst = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      if (bus.move_done) done_cnt++;
      @(negedge clk);
    end
    chk("abort_no_done", done_cnt, 0);
    chk("abort_pos_x_after", bus.pos_x, 2);
    mx = 2;
    my = 0;
    mok = 1'b0;

    // Walk to the goal down column 0; row 7 = 10001100.
    map[7] = 8'b1000_1100;
    do_reset();
    do_move(2'd3);
    do_move(2'd3);
    for (int k = 0; k < 7; k++) do_move(2'd2);
    chk("goal_reached", bus.at_goal, 1);
    chk("goal_ready", bus.move_ready, 0);
    do_move(2'd1);
    do_move(2'd0);

    // Random walks over random maps.
    for (int r = 0; r < 5; r++) begin
      for (int k = 0; k < 8; k++) map[k] = 8'($urandom | $urandom);
      do_reset();
      for (int k = 0; k < 30; k++) do_move(2'($urandom_range(0, 3)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
